// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift-mode encodings
// and the per-stage fill-bit helper.
package barrel_shift_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t SLL = 3'b000;
    localparam mode_t SRL = 3'b001;
    localparam mode_t SRA = 3'b010;
    localparam mode_t ROL = 3'b011;
    localparam mode_t ROR = 3'b100;

    // Only arithmetic right shift replicates the sign; every other shift fills with zero.
    // The sign bit survives every SRA stage, so the current MSB stays the original sign.
    function automatic logic fill_bit(input mode_t mode, input logic msb);
        logic f;
        case (mode)
            SRA:     f = msb;
            default: f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready operation bus for the barrel shifter: operation in, result out.
// slave is the shifter's view, master is the producer/consumer view.
interface pipelined_barrel_shifter_if
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    mode_t            in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_tag
    );

    modport master (
        output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_tag
    );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// One combinational 2:1 mux level of the barrel shifter: shifts or rotates by
// DIST when enabled and updates the running shifted-out (carry) bit.
module shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             carry_in,
    input  mode_t            mode,
    input  logic             shift,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    logic fill_s;

    assign fill_s = fill_bit(mode, data_in[WIDTH-1]);

    // Mux level: the carry is the last bit pushed off the edge, or the earlier carry if idle
    always_comb begin
        data_out  = data_in;
        carry_out = carry_in;
        if (shift) begin
            case (mode)
                SLL: begin
                    data_out  = {data_in[WIDTH-1-DIST:0], {DIST{fill_s}}};
                    carry_out = data_in[WIDTH-DIST];
                end
                SRL, SRA: begin
                    data_out  = {{DIST{fill_s}}, data_in[WIDTH-1:DIST]};
                    carry_out = data_in[DIST-1];
                end
                ROL: begin
                    data_out  = {data_in[WIDTH-1-DIST:0], data_in[WIDTH-1:WIDTH-DIST]};
                    carry_out = 1'b0;
                end
                ROR: begin
                    data_out  = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
                    carry_out = 1'b0;
                end
                default: begin
                    data_out  = data_in;
                    carry_out = carry_in;
                end
            endcase
        end else begin
            data_out  = data_in;
            carry_out = carry_in;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) mux levels, each followed by a register,
// advancing together under a single global enable.
module pipelined_barrel_shifter
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipelined_barrel_shifter_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    logic en_s;

    logic             valid_r [SHW];
    logic [WIDTH-1:0] data_r  [SHW];
    logic             carry_r [SHW];
    mode_t            mode_r  [SHW];
    logic [SHW-1:0]   amt_r   [SHW];
    logic [TAG_W-1:0] tag_r   [SHW];

    logic             src_valid_s [SHW];
    logic [WIDTH-1:0] src_data_s  [SHW];
    logic             src_carry_s [SHW];
    mode_t            src_mode_s  [SHW];
    logic [SHW-1:0]   src_amt_s   [SHW];
    logic [TAG_W-1:0] src_tag_s   [SHW];
    logic [WIDTH-1:0] stg_data_s  [SHW];
    logic             stg_carry_s [SHW];

    // A stall freezes the whole pipe, bubbles included, so ordering is trivially kept
    assign en_s         = bus.out_ready | ~valid_r[SHW-1];
    assign bus.in_ready = en_s;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_valid_s[k] = bus.in_valid;
            assign src_data_s[k]  = bus.in_data;
            assign src_carry_s[k] = 1'b0;
            assign src_mode_s[k]  = bus.in_mode;
            assign src_amt_s[k]   = bus.in_amt;
            assign src_tag_s[k]   = bus.in_tag;
        end else begin : g_body
            assign src_valid_s[k] = valid_r[k-1];
            assign src_data_s[k]  = data_r[k-1];
            assign src_carry_s[k] = carry_r[k-1];
            assign src_mode_s[k]  = mode_r[k-1];
            assign src_amt_s[k]   = amt_r[k-1];
            assign src_tag_s[k]   = tag_r[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_in   (src_data_s[k]),
            .carry_in  (src_carry_s[k]),
            .mode      (src_mode_s[k]),
            .shift     (src_amt_s[k][k]),
            .data_out  (stg_data_s[k]),
            .carry_out (stg_carry_s[k])
        );
    end

    // Stage registers; payload is captured only alongside a valid op, so inputs are sampled on transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SHW; i++) begin
                valid_r[i] <= 1'b0;
                data_r[i]  <= {WIDTH{1'b0}};
                carry_r[i] <= 1'b0;
                mode_r[i]  <= 3'b000;
                amt_r[i]   <= {SHW{1'b0}};
                tag_r[i]   <= {TAG_W{1'b0}};
            end
        end else if (en_s) begin
            for (int i = 0; i < SHW; i++) begin
                valid_r[i] <= src_valid_s[i];
                if (src_valid_s[i]) begin
                    data_r[i]  <= stg_data_s[i];
                    carry_r[i] <= stg_carry_s[i];
                    mode_r[i]  <= src_mode_s[i];
                    amt_r[i]   <= src_amt_s[i];
                    tag_r[i]   <= src_tag_s[i];
                end
            end
        end
    end

    assign bus.out_valid = valid_r[SHW-1];
    assign bus.out_data  = data_r[SHW-1];
    assign bus.out_carry = carry_r[SHW-1];
    assign bus.out_tag   = tag_r[SHW-1];

endmodule
